// File: rtl/exec_pkg.sv
// Shared types for the execute stage: ALU opcodes, flag bit positions, FSM states.
package exec_pkg;

  typedef enum logic [3:0] {
    ALU_PASSB = 4'd0,
    ALU_ADD   = 4'd2,
    ALU_SUB   = 4'd3,
    ALU_AND   = 4'd4,
    ALU_ORR   = 4'd5,
    ALU_EOR   = 4'd6,
    ALU_LSL   = 4'd8,
    ALU_LSR   = 4'd9,
    ALU_MUL   = 4'd10
  } alu_op_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL_RUN,
    ST_MUL_WAIT
  } state_t;

  function automatic logic [3:0] make_flags(input logic n, input logic z,
                                            input logic v, input logic c);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_V] = v;
    f[FLAG_C] = c;
    return f;
  endfunction

endpackage

// File: rtl/exec_mul_iter.sv
// Iterative shift-add multiplier retiring MUL_STEP multiplier bits per cycle.
module exec_mul_iter #(
  parameter int WIDTH    = 64,
  parameter int MUL_STEP = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] product,
  output logic [WIDTH-1:0] product_next,
  output logic             done
);

  localparam int STEPS = WIDTH / MUL_STEP;
  localparam int CNT_W = $clog2(STEPS + 1);

  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (abort) begin
      count <= '0;
    end else if (start) begin
      count <= CNT_W'(STEPS);
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
    end else if (count != '0) begin
      acc    <= product_next;
      mcand  <= mcand << MUL_STEP;
      mplier <= mplier >> MUL_STEP;
    end
  end

  always_comb begin
    product_next = acc;
    for (int i = 0; i < MUL_STEP; i++) begin
      if (mplier[i]) product_next = product_next + (mcand << i);
    end
  end

  // done marks the final step: product_next then holds the complete product.
  assign done    = (count == CNT_W'(1));
  assign product = acc;

endmodule

// File: rtl/execute_stage_mc.sv
// EX stage: forwarding muxes, single-cycle ALU, iterative MUL, registered result/NZVC
// with a valid/ready handshake toward MEM.
module execute_stage_mc
  import exec_pkg::*;
#(
  parameter  int WIDTH    = 64,
  parameter  int NUM_FWD  = 4,
  parameter  int IMM_W    = 12,
  parameter  int MUL_STEP = 1,
  localparam int FSEL_W   = $clog2(NUM_FWD + 1)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  alu_op_t                  alu_op,
  input  logic                     set_flags,
  input  logic                     alu_src,
  input  logic [IMM_W-1:0]         imm,
  input  logic [WIDTH-1:0]         da,
  input  logic [WIDTH-1:0]         db,
  input  logic [FSEL_W-1:0]        fwd_sel_a,
  input  logic [FSEL_W-1:0]        fwd_sel_b,
  input  logic [NUM_FWD*WIDTH-1:0] fwd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         alu_result,
  output logic [3:0]               flags,
  output logic                     busy
);

  localparam int SH_W = $clog2(WIDTH);

  state_t           state;
  logic             mul_sf;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH:0]   add_w, sub_w;
  logic [WIDTH-1:0] alu_res;
  logic             alu_v, alu_c, alu_def;
  logic [3:0]       alu_flags;
  logic             out_free, accept, mul_start, mul_done;
  logic [WIDTH-1:0] mul_prod, mul_prod_next;

  // Selector 0 picks the register file, 1..NUM_FWD a forwarding slot, anything else zero.
  function automatic logic [WIDTH-1:0] fwd_pick(input logic [FSEL_W-1:0] sel,
                                                input logic [WIDTH-1:0] rf,
                                                input logic [NUM_FWD*WIDTH-1:0] src);
    logic [WIDTH-1:0] v;
    v = '0;
    if (sel == '0) v = rf;
    for (int k = 0; k < NUM_FWD; k++) begin
      if (sel == FSEL_W'(k + 1)) v = src[k*WIDTH +: WIDTH];
    end
    return v;
  endfunction

  assign op_a = fwd_pick(fwd_sel_a, da, fwd_data);
  assign op_b = alu_src ? {{(WIDTH-IMM_W){1'b0}}, imm} : fwd_pick(fwd_sel_b, db, fwd_data);

  assign add_w = {1'b0, op_a} + {1'b0, op_b};
  assign sub_w = {1'b0, op_a} - {1'b0, op_b};

  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    alu_c   = 1'b0;
    alu_def = 1'b1;
    case (alu_op)
      ALU_PASSB: alu_res = op_b;
      ALU_ADD: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = ~sub_w[WIDTH];
        alu_v   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
      end
      ALU_AND:   alu_res = op_a & op_b;
      ALU_ORR:   alu_res = op_a | op_b;
      ALU_EOR:   alu_res = op_a ^ op_b;
      ALU_LSL:   alu_res = op_a << op_b[SH_W-1:0];
      ALU_LSR:   alu_res = op_a >> op_b[SH_W-1:0];
      ALU_MUL:   alu_res = '0;
      default:   alu_def = 1'b0;
    endcase
    alu_flags = make_flags(alu_res[WIDTH-1], alu_res == '0, alu_v, alu_c);
  end

  assign out_free  = !out_valid || out_ready;
  assign in_ready  = (state == ST_IDLE) && out_free;
  assign accept    = in_valid && in_ready && !flush;
  assign mul_start = accept && (alu_op == ALU_MUL);
  assign busy      = (state != ST_IDLE);

  exec_mul_iter #(
    .WIDTH   (WIDTH),
    .MUL_STEP(MUL_STEP)
  ) u_mul (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (mul_start),
    .abort       (flush),
    .a           (op_a),
    .b           (op_b),
    .product     (mul_prod),
    .product_next(mul_prod_next),
    .done        (mul_done)
  );

  // Output register stage: result/flags load only when the slot is free, so they hold under backpressure.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      out_valid  <= 1'b0;
      alu_result <= '0;
      flags      <= 4'b0000;
      mul_sf     <= 1'b0;
    end else if (flush) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (alu_op == ALU_MUL) begin
              state  <= ST_MUL_RUN;
              mul_sf <= set_flags;
            end else begin
              alu_result <= alu_res;
              out_valid  <= 1'b1;
              if (set_flags && alu_def) flags <= alu_flags;
            end
          end
        end
        ST_MUL_RUN: begin
          if (mul_done) begin
            if (out_free) begin
              alu_result <= mul_prod_next;
              out_valid  <= 1'b1;
              if (mul_sf) flags <= make_flags(mul_prod_next[WIDTH-1], mul_prod_next == '0, 1'b0, 1'b0);
              state      <= ST_IDLE;
            end else begin
              state <= ST_MUL_WAIT;
            end
          end
        end
        ST_MUL_WAIT: begin
          if (out_free) begin
            alu_result <= mul_prod;
            out_valid  <= 1'b1;
            if (mul_sf) flags <= make_flags(mul_prod[WIDTH-1], mul_prod == '0, 1'b0, 1'b0);
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_stage_mc.sv
// Scoreboard bench for execute_stage_mc: issued ops push expected {result, flags},
// a negedge monitor pops and compares on every output handshake.
module tb_execute_stage_mc;
  import exec_pkg::*;

  localparam int WIDTH    = 64;
  localparam int NUM_FWD  = 4;
  localparam int IMM_W    = 12;
  localparam int MUL_STEP = 1;
  localparam int FSEL_W   = 3;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  alu_op_t                  alu_op;
  logic                     set_flags;
  logic                     alu_src;
  logic [IMM_W-1:0]         imm;
  logic [WIDTH-1:0]         da, db;
  logic [FSEL_W-1:0]        fwd_sel_a, fwd_sel_b;
  logic [NUM_FWD*WIDTH-1:0] fwd_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         alu_result;
  logic [3:0]               flags;
  logic                     busy;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [67:0] exp_q[$];

  execute_stage_mc #(
    .WIDTH   (WIDTH),
    .NUM_FWD (NUM_FWD),
    .IMM_W   (IMM_W),
    .MUL_STEP(MUL_STEP)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .set_flags (set_flags),
    .alu_src   (alu_src),
    .imm       (imm),
    .da        (da),
    .db        (db),
    .fwd_sel_a (fwd_sel_a),
    .fwd_sel_b (fwd_sel_b),
    .fwd_data  (fwd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_result(alu_result),
    .flags     (flags),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [63:0] r, input logic [3:0] f);
    exp_q.push_back({r, f});
  endtask

  always @(negedge clk) begin
    logic [67:0] e;
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got result=%h flags=%b required no output", alu_result, flags);
      end else begin
        e = exp_q.pop_front();
        chk("sb_result", alu_result, e[67:4]);
        chk("sb_flags", 64'(flags), 64'(e[3:0]));
      end
    end
  end

  // Presents an op from posedge+1 and returns 1ns after the edge that accepts it.
  task automatic issue(input alu_op_t op, input logic sf, input logic src, input logic [11:0] im,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [2:0] sa, input logic [2:0] sb);
    int n;
    alu_op = op; set_flags = sf; alu_src = src; imm = im;
    da = a; db = b; fwd_sel_a = sa; fwd_sel_b = sb;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic mul_run(input logic [63:0] a, input logic [63:0] b, input logic sf,
                         input logic [63:0] r, input logic [3:0] f);
    int n;
    push(r, f);
    issue(ALU_MUL, sf, 1'b0, 12'd0, a, b, 3'd0, 3'd0);
    in_valid = 1'b0;
    chk("mul_busy", 64'(busy), 64'd1);
    chk("mul_in_ready_low", 64'(in_ready), 64'd0);
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("mul_latency", 64'(n), 64'd64);
    chk("mul_out_valid", 64'(out_valid), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int n;
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = ALU_ADD; set_flags = 1'b0; alu_src = 1'b0; imm = '0;
    da = '0; db = '0; fwd_sel_a = '0; fwd_sel_b = '0;
    fwd_data = {64'd11, 64'd7, 64'd3, 64'd9};
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", alu_result, 64'd0);
    chk("rst_flags", 64'(flags), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    // single-cycle ops issued back to back
    t0 = cyc;
    push(64'd15, 4'b0000);                 issue(ALU_ADD, 1, 0, 12'd0, 64'd10, 64'd5, 3'd0, 3'd0);
    push(64'd0, 4'b0101);                  issue(ALU_SUB, 1, 0, 12'd0, 64'd5, 64'd5, 3'd0, 3'd0);
    push(64'hFFFF_FFFF_FFFF_FFFF, 4'b1000); issue(ALU_SUB, 1, 0, 12'd0, 64'd0, 64'd1, 3'd0, 3'd0);
    push(64'd4096, 4'b1000);               issue(ALU_ADD, 0, 1, 12'hFFF, 64'd1, 64'd0, 3'd0, 3'd0);
    push(64'd12, 4'b0000);                 issue(ALU_ADD, 1, 0, 12'd0, 64'd0, 64'd0, 3'd2, 3'd1);
    push(64'd9, 4'b0000);                  issue(ALU_ADD, 1, 0, 12'd0, 64'd100, 64'd0, 3'd5, 3'd1);
    push(64'h8000_0000_0000_0000, 4'b1010); issue(ALU_ADD, 1, 0, 12'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'd0, 3'd0);
    push(64'd0, 4'b0101);                  issue(ALU_ADD, 1, 0, 12'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'd0, 3'd0);
    push(64'd0, 4'b0101);                  issue(alu_op_t'(4'd1), 1, 0, 12'd0, 64'd5, 64'd5, 3'd0, 3'd0);
    push(64'h8000_0000_0000_0000, 4'b1000); issue(ALU_LSL, 1, 0, 12'd0, 64'd1, 64'd63, 3'd0, 3'd0);
    push(64'h0F, 4'b1000);                 issue(ALU_LSR, 0, 0, 12'd0, 64'hF0, 64'd4, 3'd0, 3'd0);
    push(64'd2, 4'b1000);                  issue(ALU_LSL, 0, 0, 12'd0, 64'd1, 64'd65, 3'd0, 3'd0);
    push(64'h3C, 4'b0000);                 issue(ALU_AND, 1, 0, 12'd0, 64'hFC, 64'h3F, 3'd0, 3'd0);
    push(64'hFF, 4'b0000);                 issue(ALU_ORR, 0, 0, 12'd0, 64'hF0, 64'h0F, 3'd0, 3'd0);
    push(64'hF0, 4'b0000);                 issue(ALU_EOR, 0, 0, 12'd0, 64'hFF, 64'h0F, 3'd0, 3'd0);
    push(64'd77, 4'b0000);                 issue(ALU_PASSB, 0, 0, 12'd0, 64'd5, 64'd77, 3'd0, 3'd0);
    in_valid = 1'b0;
    chk("back_to_back_cycles", 64'(cyc - t0), 64'd16);
    @(posedge clk); #1;
    chk("drain_out_valid", 64'(out_valid), 64'd0);

    // multi-cycle multiplies
    mul_run(64'd7, 64'd6, 1'b1, 64'd42, 4'b0000);
    mul_run(64'h1_0000_0003, 64'h1_0000_0005, 1'b0, 64'h0000_0008_0000_000F, 4'b0000);
    mul_run(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000);

    // MUL completing into a stalled MEM stage
    push(64'd12, 4'b0000);
    issue(ALU_MUL, 1, 0, 12'd0, 64'd3, 64'd4, 3'd0, 3'd0);
    in_valid = 1'b0;
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("stall_mul_latency", 64'(n), 64'd64);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("hold_result", alu_result, 64'd12);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_out_valid", 64'(out_valid), 64'd0);

    // asynchronous reset in the middle of a MUL
    push(64'hFFFF_FFFF_FFFF_FFFF, 4'b1000);
    issue(ALU_SUB, 1, 0, 12'd0, 64'd0, 64'd1, 3'd0, 3'd0);
    issue(ALU_MUL, 1, 0, 12'd0, 64'd3, 64'd3, 3'd0, 3'd0);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midmul_rst_busy", 64'(busy), 64'd0);
    chk("midmul_rst_out_valid", 64'(out_valid), 64'd0);
    chk("midmul_rst_flags", 64'(flags), 64'd0);
    chk("midmul_rst_result", alu_result, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (70) @(posedge clk);
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // flush in the middle of a MUL
    push(64'hFFFF_FFFF_FFFF_FFFF, 4'b1000);
    issue(ALU_SUB, 1, 0, 12'd0, 64'd0, 64'd1, 3'd0, 3'd0);
    issue(ALU_MUL, 1, 0, 12'd0, 64'd5, 64'd5, 3'd0, 3'd0);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_flags", 64'(flags), 64'(4'b1000));
    chk("flush_in_ready", 64'(in_ready), 64'd1);

    // flush coinciding with an accept drops the op
    alu_op = ALU_ADD; set_flags = 1'b1; alu_src = 1'b0;
    da = 64'd2; db = 64'd2; fwd_sel_a = '0; fwd_sel_b = '0;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_accept_out_valid", 64'(out_valid), 64'd0);
    chk("flush_accept_flags", 64'(flags), 64'(4'b1000));

    push(64'd5, 4'b0000);
    issue(ALU_ADD, 1, 0, 12'd0, 64'd2, 64'd3, 3'd0, 3'd0);
    in_valid = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
